// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: pops one packet per burst from a FWFT FIFO and forwards it
// through a valid/ready output register, leaving a guaranteed RE-low gap after
// each packet so the upstream word counter decrements exactly once per packet.
//
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   PKT_CNT      packets pending from the FIFO word counter
//   FIFO_DOUT    FWFT head word, bit 16 = end-of-packet, bits 15:0 = data
//   FIFO_EMPTY   FIFO empty
//   FIFO_RE      FIFO pop, also the counter's RE (combinational, low in reset)
//   DOUT/DV      output data / valid
//   EOP_OUT/ERR  last word of packet / abnormal termination (valid with EOP_OUT)
//   RDY          downstream accepts when DV && RDY
//   BUSY         state is not IDLE
//   PKT_TOTAL    packets accepted downstream
//   ERR_TOTAL    packets accepted downstream with ERR
//
// Build option: define FIFO_PKT_RD_STATS_EN to build the PKT_TOTAL/ERR_TOTAL
// counters; otherwise both ports are tied to zero.
module fifo_pkt_reader #(
    parameter int          WIDTH     = 16,
    parameter int          MAX_WORDS = 1024,
    parameter int          TIMEOUT   = 255,
    parameter logic [15:0] PAD_WORD  = 16'hDEAD
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] PKT_CNT,
    input  logic [16:0]      FIFO_DOUT,
    input  logic             FIFO_EMPTY,
    output logic             FIFO_RE,
    output logic [15:0]      DOUT,
    output logic             DV,
    output logic             EOP_OUT,
    output logic             ERR,
    input  logic             RDY,
    output logic             BUSY,
    output logic [15:0]      PKT_TOTAL,
    output logic [15:0]      ERR_TOTAL
);
    localparam int WW = $clog2(MAX_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, READ, GAP0, GAP1} state_t;

    state_t        state, state_n;
    logic [WW-1:0] wcnt;
    logic [TW-1:0] tcnt;
    logic          free, pop, tmo, max_hit, done;

    assign free    = !DV || RDY;
    assign pop     = !RST && state == READ && !FIFO_EMPTY && free;
    assign FIFO_RE = pop;
    assign max_hit = wcnt == WW'(MAX_WORDS - 1);
    // Pad trailer is only inserted once the output register can take it.
    assign tmo     = state == READ && FIFO_EMPTY && free && tcnt == TW'(TIMEOUT);
    assign done    = (pop && (FIFO_DOUT[16] || max_hit)) || tmo;
    assign BUSY    = state != IDLE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (PKT_CNT != '0 && !FIFO_EMPTY) ? READ : IDLE;
            READ:    state_n = done ? GAP0 : READ;
            GAP0:    state_n = GAP1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            wcnt  <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= (state != READ) ? '0 : (pop && wcnt != WW'(MAX_WORDS)) ? wcnt + 1'b1 : wcnt;
            // Counts consecutive empty cycles; any non-empty cycle (incl. every pop) restarts it.
            tcnt  <= (state != READ || !FIFO_EMPTY) ? '0 : (tcnt != TW'(TIMEOUT)) ? tcnt + 1'b1 : tcnt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            DOUT    <= '0;
            DV      <= 1'b0;
            EOP_OUT <= 1'b0;
            ERR     <= 1'b0;
        end else if (pop) begin
            DOUT    <= FIFO_DOUT[15:0];
            DV      <= 1'b1;
            EOP_OUT <= FIFO_DOUT[16] || max_hit;
            ERR     <= !FIFO_DOUT[16] && max_hit;
        end else if (tmo) begin
            DOUT    <= PAD_WORD;
            DV      <= 1'b1;
            EOP_OUT <= 1'b1;
            ERR     <= 1'b1;
        end else if (RDY) begin
            DV      <= 1'b0;
        end
    end

`ifdef FIFO_PKT_RD_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            PKT_TOTAL <= '0;
            ERR_TOTAL <= '0;
        end else if (DV && RDY && EOP_OUT) begin
            PKT_TOTAL <= PKT_TOTAL + 16'd1;
            ERR_TOTAL <= ERR ? ERR_TOTAL + 16'd1 : ERR_TOTAL;
        end
    end
`else
    assign PKT_TOTAL = '0;
    assign ERR_TOTAL = '0;
`endif
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// tb_fifo_pkt_reader: directed scoreboard bench for fifo_pkt_reader with a
// FWFT FIFO model and a packet counter that decrements on each RE trailing edge.
module tb_fifo_pkt_reader;
`ifdef FIFO_PKT_RD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] pkt_cnt;
    logic [16:0] fifo_dout;
    logic        fifo_empty;
    logic        FIFO_RE;
    logic [15:0] DOUT;
    logic        DV, EOP_OUT, ERR, BUSY;
    logic        RDY;
    logic [15:0] PKT_TOTAL, ERR_TOTAL;

    logic [16:0] mem [0:63];
    logic [7:0]  rp, wp;
    logic [15:0] pkt_add;
    logic        flush, re_q;

    logic [17:0] sb [$];
    int          checks = 0, errors = 0;
    int          exp_pkt = 0, exp_err = 0;
    int          bursts = 0, cur_len = 0, last_len = 0, low_run = 0, pops = 0;
    logic        re_prev = 1'b0, eop_popped = 1'b0, hold_prev = 1'b0, seen_one = 1'b0;
    logic [17:0] held;

    always #5 CLK = ~CLK;

    fifo_pkt_reader #(.WIDTH(16), .MAX_WORDS(8), .TIMEOUT(255), .PAD_WORD(16'hDEAD)) dut (
        .CLK(CLK), .RST(RST), .PKT_CNT(pkt_cnt), .FIFO_DOUT(fifo_dout),
        .FIFO_EMPTY(fifo_empty), .FIFO_RE(FIFO_RE), .DOUT(DOUT), .DV(DV),
        .EOP_OUT(EOP_OUT), .ERR(ERR), .RDY(RDY), .BUSY(BUSY),
        .PKT_TOTAL(PKT_TOTAL), .ERR_TOTAL(ERR_TOTAL)
    );

    assign fifo_dout  = mem[rp[5:0]];
    assign fifo_empty = rp == wp;

    // FIFO pop and word-counter model: one decrement per RE falling edge.
    always @(posedge CLK) begin
        re_q <= FIFO_RE;
        if (flush) begin
            rp      <= wp;
            pkt_cnt <= '0;
        end else begin
            if (FIFO_RE) rp <= rp + 8'd1;
            pkt_cnt <= pkt_cnt + pkt_add - ((re_q && !FIFO_RE && pkt_cnt != 16'd0) ? 16'd1 : 16'd0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: monitor at negedge (inputs and outputs stable), return at posedge+1.
    task automatic cyc();
        logic [17:0] e;
        @(negedge CLK);
        if (hold_prev) chk("hold_stable", {DV, EOP_OUT, ERR, DOUT}, {1'b1, held});
        if (DV && !RDY) chk("re_low_when_stalled", FIFO_RE, 0);
        hold_prev = DV && !RDY;
        held = {EOP_OUT, ERR, DOUT};
        if (DV && RDY) begin
            if (sb.size() == 0) chk("unexpected_word", sb.size(), 1);
            else begin
                e = sb.pop_front();
                chk("word", {EOP_OUT, ERR, DOUT}, e);
                if (e[17]) begin
                    exp_pkt++;
                    if (e[16]) exp_err++;
                end
            end
        end
        if (FIFO_RE) begin
            if (!re_prev) begin
                bursts++;
                if (eop_popped) chk("gap_ge_3", low_run >= 3, 1);
                eop_popped = 1'b0;
                cur_len = 0;
            end
            cur_len++;
            low_run = 0;
            pops++;
            if (fifo_dout[16]) eop_popped = 1'b1;
        end else begin
            if (re_prev) last_len = cur_len;
            low_run++;
        end
        re_prev = FIFO_RE;
        if (pkt_cnt == 16'd1) seen_one = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic drain(input int lim, input string tag);
        int n = 0;
        while (n < lim && !(sb.size() == 0 && !BUSY && !DV)) begin
            cyc();
            n++;
        end
        chk(tag, n < lim, 1);
    endtask

    task automatic push_word(input logic [16:0] w);
        mem[wp[5:0]] = w;
        wp = wp + 8'd1;
    endtask

    task automatic push_pkt(input int n, input logic [15:0] base, input logic eop_last);
        for (int i = 0; i < n; i++) begin
            push_word({eop_last && i == n - 1, base + 16'(i)});
            sb.push_back({eop_last && i == n - 1, 1'b0, base + 16'(i)});
        end
    endtask

    task automatic add(input logic [15:0] n);
        pkt_add = n;
        cyc();
        pkt_add = '0;
    endtask

    initial begin
        int b0, p0, n;
        RST = 1'b1; RDY = 1'b1; pkt_add = '0; flush = 1'b1; wp = '0;
        run(3);
        flush = 1'b0; RST = 1'b0;
        chk("rst_dv", DV, 0);
        chk("rst_dout", DOUT, 0);
        chk("rst_eop", EOP_OUT, 0);
        chk("rst_err", ERR, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_re", FIFO_RE, 0);
        chk("rst_pkt_total", PKT_TOTAL, 0);
        chk("rst_err_total", ERR_TOTAL, 0);

        // Single 4-word packet.
        push_pkt(4, 16'h1000, 1'b1);
        b0 = bursts;
        add(1);
        drain(50, "t1_done");
        run(10);
        chk("t1_bursts", bursts - b0, 1);
        chk("t1_len", last_len, 4);
        chk("t1_cnt", pkt_cnt, 0);
        chk("t1_no_more_reads", low_run >= 10, 1);

        // Two queued packets.
        push_pkt(3, 16'h2000, 1'b1);
        push_pkt(2, 16'h3000, 1'b1);
        seen_one = 1'b0;
        b0 = bursts;
        add(2);
        drain(80, "t2_done");
        run(10);
        chk("t2_bursts", bursts - b0, 2);
        chk("t2_last_len", last_len, 2);
        chk("t2_seen_cnt1", seen_one, 1);
        chk("t2_cnt", pkt_cnt, 0);

        // Backpressure during a 5-word packet.
        push_pkt(5, 16'h4000, 1'b1);
        p0 = pops;
        add(1);
        n = 0;
        while (!DV && n < 20) begin cyc(); n++; end
        chk("t3_dv_seen", DV, 1);
        cyc();
        RDY = 1'b0;
        run(2);
        RDY = 1'b1;
        drain(50, "t3_done");
        chk("t3_pops", pops - p0, 5);

        // Timeout after 2 words with no EOP.
        push_pkt(2, 16'h5000, 1'b0);
        sb.push_back({1'b1, 1'b1, 16'hDEAD});
        add(1);
        drain(400, "t4_done");
        chk("t4_pkt_total", PKT_TOTAL, STATS ? exp_pkt : 0);
        chk("t4_err_total", ERR_TOTAL, STATS ? exp_err : 0);

        // 10-word packet against MAX_WORDS=8.
        for (int i = 0; i < 10; i++) begin
            push_word({i == 9, 16'h6000 + 16'(i)});
            if (i < 8) sb.push_back({i == 7, i == 7, 16'h6000 + 16'(i)});
        end
        b0 = bursts;
        add(1);
        drain(60, "t5_first");
        run(10);
        chk("t5_idle_busy", BUSY, 0);
        chk("t5_left", wp - rp, 2);
        sb.push_back({1'b0, 1'b0, 16'h6008});
        sb.push_back({1'b1, 1'b0, 16'h6009});
        add(1);
        drain(40, "t5_second");
        chk("t5_bursts", bursts - b0, 2);
        chk("t5_err_total", ERR_TOTAL, STATS ? exp_err : 0);

        // Reset in the middle of READ.
        push_pkt(6, 16'h7000, 1'b1);
        add(1);
        n = 0;
        while (!FIFO_RE && n < 20) begin cyc(); n++; end
        chk("t6_re_seen", FIFO_RE, 1);
        run(2);
        RST = 1'b1; flush = 1'b1;
        @(negedge CLK);
        chk("t6_re_in_rst", FIFO_RE, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0; flush = 1'b0;
        sb.delete();
        hold_prev = 1'b0;
        exp_pkt = 0; exp_err = 0;
        chk("t6_dv", DV, 0);
        chk("t6_busy", BUSY, 0);
        run(5);
        chk("t6_still_idle", BUSY, 0);
        chk("t6_pkt_total", PKT_TOTAL, 0);
        push_pkt(2, 16'h8000, 1'b1);
        add(1);
        drain(40, "t6_recover");
        chk("t6_pkt_total_after", PKT_TOTAL, STATS ? exp_pkt : 0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
